divider_param: RTL and testbench

Parametrised signed/unsigned integer divider, the successor to the fixed 32-bit signed divider_dshift.
- Width is set by a parameter; signed or unsigned mode is chosen per operation.
- Divide-by-zero and signed-overflow cases are detected and flagged explicitly.
- Iterative restoring shift-subtract, one quotient bit per cycle, using the same start/ready handshake.
- Sits as a multi-cycle execution unit behind an issue stage.

---
 rtl/divider_pkg.sv | 27 ++
 rtl/divider_param_if.sv | 25 ++
 rtl/divider_lzc.sv | 24 ++
 rtl/divider_param.sv | 165 ++++++++++++++++
 tb/tb_divider_param.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// Shared types and constant helpers for the parametrised divider.
package divider_pkg;

  localparam int MAX_WIDTH = 128;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Most negative two's-complement value of the given width, zero-extended.
  function automatic logic [MAX_WIDTH-1:0] min_val(input int width);
    return MAX_WIDTH'(1) << (width - 1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] all_ones(input int width);
    return (MAX_WIDTH'(1) << width) - MAX_WIDTH'(1);
  endfunction

endpackage

// File: rtl/divider_param_if.sv
// Issue-side handshake and result bundle of the divider.
interface divider_param_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, ready, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, ready, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/divider_lzc.sv
// Leading-zero counter; returns WIDTH for an all-zero input.
module divider_lzc
  import divider_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic [WIDTH-1:0] i_val,
  output logic [CW-1:0]    o_cnt
);

  logic [CW-1:0] w_cnt;

  // Scan upward so the highest set bit wins.
  always_comb begin
    w_cnt = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt = i_val[i] ? CW'(WIDTH - 1 - i) : w_cnt;
    end
  end

  assign o_cnt = w_cnt;

endmodule

// File: rtl/divider_param.sv
// Iterative restoring signed/unsigned divider, one quotient bit per cycle.
// Define DIVIDER_EARLY_TERM_EN to skip the dividend's leading zeros in CALC.
module divider_param
  import divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  divider_param_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_e           r_state;
  logic             r_busy;
  logic             r_ready;
  logic             r_signed;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_dbz;
  logic             r_ovf;
  logic [WIDTH-1:0] r_dd;
  logic [WIDTH-1:0] r_dr;
  logic [WIDTH-1:0] r_dr_mag;
  logic [WIDTH-1:0] r_dq;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_min;
  logic [WIDTH-1:0] w_neg1;
  logic             w_dd_neg;
  logic             w_dr_neg;
  logic [WIDTH-1:0] w_dd_mag;
  logic [WIDTH-1:0] w_dr_mag;
  logic [WIDTH-1:0] w_dq_init;
  logic [CW-1:0]    w_iter;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;

  assign w_min  = WIDTH'(min_val(WIDTH));
  assign w_neg1 = WIDTH'(all_ones(WIDTH));

  assign w_dd_neg = r_signed & r_dd[WIDTH-1];
  assign w_dr_neg = r_signed & r_dr[WIDTH-1];
  assign w_dd_mag = w_dd_neg ? -r_dd : r_dd;
  assign w_dr_mag = w_dr_neg ? -r_dr : r_dr;

`ifdef DIVIDER_EARLY_TERM_EN
  logic [CW-1:0] w_lz;

  divider_lzc #(.WIDTH(WIDTH), .CW(CW)) u_lzc (
    .i_val (w_dd_mag),
    .o_cnt (w_lz)
  );

  // Leading zeros only produce zero quotient bits, so they are shifted out up front.
  assign w_dq_init = w_dd_mag << w_lz;
  assign w_iter    = (w_lz == CW'(WIDTH)) ? CW'(1) : (CW'(WIDTH) - w_lz);
`else
  assign w_dq_init = w_dd_mag;
  assign w_iter    = CW'(WIDTH);
`endif

  // The partial remainder is always below 2*|divisor|, so the MSB of the
  // (WIDTH+1)-bit difference is a reliable borrow.
  assign w_shift = {r_rem, r_dq[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dr_mag};
  assign w_ge    = ~w_diff[WIDTH];

  // Control FSM, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_ready  <= 1'b0;
      r_signed <= 1'b0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_dbz    <= 1'b0;
      r_ovf    <= 1'b0;
      r_dd     <= '0;
      r_dr     <= '0;
      r_dr_mag <= '0;
      r_dq     <= '0;
      r_rem    <= '0;
      r_quot   <= '0;
      r_remo   <= '0;
      r_cnt    <= '0;
    end else begin
      r_ready <= 1'b0;
      r_busy  <= 1'b1;
      case (r_state)
        IDLE: begin
          r_busy <= bus.start;
          if (bus.start) begin
            r_dd     <= bus.dividend;
            r_dr     <= bus.divisor;
            r_signed <= bus.is_signed;
            r_dbz    <= 1'b0;
            r_ovf    <= 1'b0;
            r_state  <= PREP;
          end else begin
            r_state <= IDLE;
          end
        end
        PREP: begin
          r_sign_q <= w_dd_neg ^ w_dr_neg;
          r_sign_r <= w_dd_neg;
          r_dr_mag <= w_dr_mag;
          r_dq     <= w_dq_init;
          r_rem    <= '0;
          r_cnt    <= w_iter;
          if (r_dr == '0) begin
            r_quot  <= '1;
            r_remo  <= r_dd;
            r_dbz   <= 1'b1;
            r_state <= DONE;
          end else if (r_signed && (r_dd == w_min) && (r_dr == w_neg1)) begin
            r_quot  <= w_min;
            r_remo  <= '0;
            r_ovf   <= 1'b1;
            r_state <= DONE;
          end else begin
            r_state <= CALC;
          end
        end
        CALC: begin
          r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_dq  <= {r_dq[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= FIX;
          end else begin
            r_state <= CALC;
          end
        end
        FIX: begin
          r_quot  <= r_sign_q ? -r_dq : r_dq;
          r_remo  <= r_sign_r ? -r_rem : r_rem;
          r_state <= DONE;
        end
        DONE: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.ready       = r_ready;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_remo;
  assign bus.div_by_zero = r_dbz;
  assign bus.overflow    = r_ovf;

endmodule

// File: tb/tb_divider_param.sv
// Self-checking bench: 32-bit and 8-bit dividers against an arithmetic reference model.
module tb_divider_param;

`ifdef DIVIDER_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  divider_param_if #(.WIDTH(32)) bus0 ();
  divider_param_if #(.WIDTH(8))  bus1 ();

  divider_param #(.WIDTH(32)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  divider_param #(.WIDTH(8))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    bit          dbz;
    bit          ovf;
    int          lat;
    int          acc;
    int          due;
  } exp_t;

  int   n_err = 0;
  int   n_chk = 0;
  int   cyc   = 0;
  bit   pend [2];
  bit   zchk [2];
  exp_t ex   [2];

  always @(posedge clk) cyc <= cyc + 1;

  // Truncating division straight from the arithmetic definition.
  function automatic exp_t model(input int w, input logic [31:0] a_in,
                                 input logic [31:0] b_in, input bit sg);
    longint m, a, b, sa, sb, half;
    exp_t e;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    a    = longint'({32'd0, a_in}) & m;
    b    = longint'({32'd0, b_in}) & m;
    sa   = (sg && a >= half) ? a - (m + 1) : a;
    sb   = (sg && b >= half) ? b - (m + 1) : b;
    e.dbz = 1'b0; e.ovf = 1'b0; e.acc = 0; e.due = 0;
    if (sb == 0) begin
      e.q = 32'(m); e.r = 32'(a); e.dbz = 1'b1; e.lat = 2;
    end else if (sg && sa == -half && sb == -1) begin
      e.q = 32'(a); e.r = 32'd0; e.ovf = 1'b1; e.lat = 2;
    end else begin
      e.q   = 32'((sa / sb) & m);
      e.r   = 32'((sa % sb) & m);
      e.lat = w + 3;
`ifdef DIVIDER_EARLY_TERM_EN
      begin
        longint mag;
        int bl;
        mag = (sa < 0) ? -sa : sa;
        bl  = 0;
        for (int i = 0; i < w; i++) if (mag[i]) bl = i + 1;
        e.lat = ((bl > 1) ? bl : 1) + 3;
      end
`endif
    end
    return e;
  endfunction

  task automatic pin(input string nm, input exp_t e, input logic [31:0] q,
                     input logic [31:0] r, input bit dbz, input bit ovf, input int lat);
    n_chk++;
    if (e.q !== q || e.r !== r || e.dbz !== dbz || e.ovf !== ovf || e.lat != lat) begin
      n_err++;
      $display("FAIL pin_%0s: got q=%h r=%h dbz=%0d ovf=%0d lat=%0d, want q=%h r=%h dbz=%0d ovf=%0d lat=%0d",
               nm, e.q, e.r, e.dbz, e.ovf, e.lat, q, r, dbz, ovf, lat);
    end
  endtask

  task automatic mon(input int d, input int w, input logic st, input logic sg,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic busy, input logic rdy, input logic [31:0] q,
                     input logic [31:0] r, input logic dbz, input logic ovf);
    if (zchk[d]) begin
      zchk[d] = 1'b0;
      n_chk++;
      if ({busy, rdy, dbz, ovf} !== 4'b0000 || q !== 32'd0 || r !== 32'd0) begin
        n_err++;
        $display("FAIL reset_state dut%0d cyc=%0d: got busy=%b rdy=%b dbz=%b ovf=%b q=%h r=%h, want all 0",
                 d, cyc, busy, rdy, dbz, ovf, q, r);
      end
    end
    n_chk++;
    if (busy !== pend[d]) begin
      n_err++;
      $display("FAIL busy dut%0d cyc=%0d: got %b want %b", d, cyc, busy, pend[d]);
    end
    if (pend[d] && cyc == ex[d].acc) begin
      n_chk++;
      if ({dbz, ovf} !== 2'b00) begin
        n_err++;
        $display("FAIL flags_clear dut%0d cyc=%0d: got dbz=%b ovf=%b want 0 0", d, cyc, dbz, ovf);
      end
    end
    if (rdy === 1'b1) begin
      n_chk++;
      if (!pend[d] || cyc != ex[d].due) begin
        n_err++;
        $display("FAIL ready_time dut%0d: got ready at cyc=%0d, want pending=%0d due=%0d",
                 d, cyc, pend[d], ex[d].due);
      end else begin
        n_chk++;
        if (q !== ex[d].q || r !== ex[d].r || dbz !== ex[d].dbz || ovf !== ex[d].ovf) begin
          n_err++;
          $display("FAIL result dut%0d cyc=%0d: got q=%h r=%h dbz=%b ovf=%b, want q=%h r=%h dbz=%b ovf=%b",
                   d, cyc, q, r, dbz, ovf, ex[d].q, ex[d].r, ex[d].dbz, ex[d].ovf);
        end
      end
      pend[d] = 1'b0;
    end else if (pend[d] && cyc >= ex[d].due) begin
      n_chk++;
      n_err++;
      $display("FAIL no_ready dut%0d: got no ready at cyc=%0d, want ready at %0d", d, cyc, ex[d].due);
      pend[d] = 1'b0;
    end
    if (rst === 1'b0) begin
      pend[d] = 1'b0;
      zchk[d] = 1'b1;
    end else if (st === 1'b1 && !pend[d]) begin
      pend[d]   = 1'b1;
      ex[d]     = model(w, a, b, sg);
      ex[d].acc = cyc + 1;
      ex[d].due = cyc + 1 + ex[d].lat;
    end
  endtask

  // Single compare process for both dividers.
  always @(negedge clk) begin
    mon(0, 32, bus0.start, bus0.is_signed, bus0.dividend, bus0.divisor, bus0.busy,
        bus0.ready, bus0.quotient, bus0.remainder, bus0.div_by_zero, bus0.overflow);
    mon(1, 8, bus1.start, bus1.is_signed, 32'(bus1.dividend), 32'(bus1.divisor), bus1.busy,
        bus1.ready, 32'(bus1.quotient), 32'(bus1.remainder), bus1.div_by_zero, bus1.overflow);
  end

  function automatic logic [31:0] rnd(input int w);
    logic [31:0] v;
    logic [31:0] msk;
    msk = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'd1 << (w - 1);
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'd1;
      4:       v = 32'($urandom_range(0, 20));
      5:       v = 32'd0 - 32'($urandom_range(1, 20));
      default: v = $urandom;
    endcase
    return v & msk;
  endfunction

  task automatic wait_idle(input int d);
    int g;
    g = 0;
    while (((d == 0) ? bus0.busy : bus1.busy) !== 1'b0 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    n_chk++;
    if (g >= 200) begin
      n_err++;
      $display("FAIL idle_timeout dut%0d: got busy after %0d cycles, want idle", d, g);
    end
  endtask

  task automatic issue(input int d, input logic [31:0] a, input logic [31:0] b,
                       input logic sg, input bit wait_done);
    if (d == 0) begin
      bus0.dividend = a; bus0.divisor = b; bus0.is_signed = sg; bus0.start = 1'b1;
    end else begin
      bus1.dividend = 8'(a); bus1.divisor = 8'(b); bus1.is_signed = sg; bus1.start = 1'b1;
    end
    @(posedge clk); #1;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    if (wait_done) wait_idle(d);
  endtask

  initial begin
    rst = 1'b0;
    bus0.start = 1'b0; bus0.is_signed = 1'b0; bus0.dividend = '0; bus0.divisor = '0;
    bus1.start = 1'b0; bus1.is_signed = 1'b0; bus1.dividend = '0; bus1.divisor = '0;

    pin("u100_7",   model(32, 32'd100, 32'd7, 1'b0), 32'd14, 32'd2, 1'b0, 1'b0, ET ? 10 : 35);
    pin("sn100_7",  model(32, 32'hFFFF_FF9C, 32'd7, 1'b1), 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, ET ? 10 : 35);
    pin("s100_n7",  model(32, 32'd100, 32'hFFFF_FFF9, 1'b1), 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0, ET ? 10 : 35);
    pin("s_ovf",    model(32, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1), 32'h8000_0000, 32'd0, 1'b0, 1'b1, 2);
    pin("u_minneg", model(32, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0), 32'd0, 32'h8000_0000, 1'b0, 1'b0, 35);
    pin("dbz",      model(32, 32'd5, 32'd0, 1'b1), 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0, 2);
    pin("u9_3",     model(32, 32'd9, 32'd3, 1'b0), 32'd3, 32'd0, 1'b0, 1'b0, ET ? 7 : 35);
    pin("w8_ovf",   model(8, 32'h80, 32'hFF, 1'b1), 32'h80, 32'd0, 1'b0, 1'b1, 2);
    pin("w8_sn7_2", model(8, 32'hF9, 32'd2, 1'b1), 32'hFD, 32'hFF, 1'b0, 1'b0, ET ? 6 : 11);

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    issue(0, 32'd100, 32'd7, 1'b0, 1'b1);
    issue(0, 32'hFFFF_FF9C, 32'd7, 1'b1, 1'b1);
    issue(0, 32'd100, 32'hFFFF_FFF9, 1'b1, 1'b1);
    issue(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    issue(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    issue(0, 32'd5, 32'd0, 1'b1, 1'b1);
    issue(0, 32'd5, 32'd0, 1'b0, 1'b1);
    issue(1, 32'h80, 32'hFF, 1'b1, 1'b1);
    issue(1, 32'hF9, 32'd2, 1'b1, 1'b1);

    // Abort a division mid-CALC, then confirm the unit still works.
    issue(0, 32'd1000, 32'd3, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    repeat (45) @(posedge clk);
    #1;
    issue(0, 32'd9, 32'd3, 1'b0, 1'b1);

    // Continuous start with operands changing every cycle.
    bus0.start = 1'b1;
    bus1.start = 1'b1;
    for (int c = 0; c < 30000 && n_err < 100; c++) begin
      bus0.dividend  = rnd(32);
      bus0.divisor   = rnd(32);
      bus0.is_signed = 1'($urandom_range(0, 1));
      bus1.dividend  = 8'(rnd(8));
      bus1.divisor   = 8'(rnd(8));
      bus1.is_signed = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    wait_idle(0);
    wait_idle(1);
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
